// File: rtl/ppu_reg_port.sv
// ppu_reg_port: CPU-side PPU register file ($2000-$2007) with VRAM/OAM bridging.
// Optional macro PPU_PALETTE_DIRECT_EN: palette-range PPUDATA reads return VRAM data on ack.
module ppu_reg_port #(
    parameter int                 VADDR_W  = 14,
    parameter logic [VADDR_W-1:0] PAL_BASE = 14'h3F00
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_cs,
    input  logic               i_rw,
    input  logic [2:0]         i_reg_sel,
    input  logic [7:0]         i_cpu_wdata,
    output logic [7:0]         o_cpu_rdata,
    output logic               o_nmi_n,
    input  logic               i_vblank_set,
    input  logic               i_frame_clr,
    input  logic               i_spr0_hit,
    input  logic               i_spr_ovf,
    output logic [7:0]         o_ppu_ctrl,
    output logic [7:0]         o_ppu_mask,
    output logic [7:0]         o_scroll_x,
    output logic [7:0]         o_scroll_y,
    output logic [7:0]         o_oam_addr,
    output logic               o_oam_wr,
    output logic [7:0]         o_oam_wdata,
    input  logic [7:0]         i_oam_rdata,
    output logic [VADDR_W-1:0] o_vram_addr,
    output logic               o_vram_req,
    output logic               o_vram_we,
    output logic [7:0]         o_vram_wdata,
    input  logic [7:0]         i_vram_rdata,
    input  logic               i_vram_ack
);
    localparam logic [1:0] S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2;
    logic [1:0]         r_state;
    logic [7:0]         r_ctrl, r_mask, r_sx, r_sy, r_oam_addr, r_oam_wdata, r_wdata, r_buf, r_io, r_rdata;
    logic               r_oam_wr, r_req, r_we, r_w, r_vbl, r_spr0, r_ovf, r_nmi_n, r_pal;
    logic [VADDR_W-1:0] r_vaddr;
    logic               r_sh_hi_v, r_sh_lo_v;
    logic [VADDR_W-9:0] r_sh_hi;
    logic [7:0]         r_sh_lo;
    logic               w_rd, w_wr, w_idle, w_rd2, w_acc7, w_done, w_sh_wr, w_hi_v, w_lo_v, w_pal_rd;
    logic [VADDR_W-9:0] w_hi;
    logic [7:0]         w_lo, w_status, w_rval;
    logic [VADDR_W-1:0] w_inc, w_vnext, w_vpost;
    assign w_rd    = i_cs & i_rw;
    assign w_wr    = i_cs & ~i_rw;
    assign w_idle  = r_state == S_IDLE;
    assign w_rd2   = w_rd & (i_reg_sel == 3'd2);
    assign w_acc7  = i_cs & (i_reg_sel == 3'd7);
    assign w_done  = ~w_idle & i_vram_ack;
    // PPUADDR writes during a transfer accumulate here and overlay the post-increment pointer
    assign w_sh_wr = w_wr & (i_reg_sel == 3'd6) & ~w_idle;
    assign w_hi_v  = r_sh_hi_v | (w_sh_wr & ~r_w);
    assign w_lo_v  = r_sh_lo_v | (w_sh_wr & r_w);
    assign w_hi    = (w_sh_wr & ~r_w) ? i_cpu_wdata[VADDR_W-9:0] : r_sh_hi;
    assign w_lo    = (w_sh_wr & r_w) ? i_cpu_wdata : r_sh_lo;
    assign w_inc   = r_ctrl[2] ? VADDR_W'(32) : VADDR_W'(1);
    assign w_vnext = r_vaddr + w_inc;
    assign w_vpost = {w_hi_v ? w_hi : w_vnext[VADDR_W-1:8], w_lo_v ? w_lo : w_vnext[7:0]};
    assign w_status = {r_vbl & ~i_vblank_set, r_spr0, r_ovf, r_io[4:0]};
    assign w_rval  = (i_reg_sel == 3'd2) ? w_status :
                     (i_reg_sel == 3'd4) ? i_oam_rdata :
                     (i_reg_sel == 3'd7) ? r_buf : r_io;
`ifdef PPU_PALETTE_DIRECT_EN
    assign w_pal_rd = w_rd & w_idle & (i_reg_sel == 3'd7) & (r_vaddr >= PAL_BASE);
`else
    assign w_pal_rd = 1'b0;
`endif
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_ctrl <= '0; r_mask <= '0; r_sx <= '0; r_sy <= '0;
            r_oam_addr <= '0; r_oam_wdata <= '0; r_oam_wr <= 1'b0;
            r_wdata <= '0; r_buf <= '0; r_io <= '0; r_rdata <= '0;
            r_req <= 1'b0; r_we <= 1'b0; r_w <= 1'b0; r_pal <= 1'b0;
            r_vbl <= 1'b0; r_spr0 <= 1'b0; r_ovf <= 1'b0; r_nmi_n <= 1'b1;
            r_vaddr <= '0;
            r_sh_hi_v <= 1'b0; r_sh_lo_v <= 1'b0; r_sh_hi <= '0; r_sh_lo <= '0;
        end else begin
            r_vbl    <= w_rd2 ? 1'b0 : i_vblank_set ? 1'b1 : i_frame_clr ? 1'b0 : r_vbl;
            r_spr0   <= i_spr0_hit ? 1'b1 : i_frame_clr ? 1'b0 : r_spr0;
            r_ovf    <= i_spr_ovf ? 1'b1 : i_frame_clr ? 1'b0 : r_ovf;
            r_nmi_n  <= ~(r_vbl & r_ctrl[7]);
            r_oam_wr <= w_wr & (i_reg_sel == 3'd4);
            if (r_oam_wr) r_oam_addr <= r_oam_addr + 8'd1;
            if (w_rd && !w_pal_rd) begin
                r_rdata <= w_rval;
                r_io    <= w_rval;
            end
            if (w_wr) begin
                r_io <= i_cpu_wdata;
                case (i_reg_sel)
                    3'd0: r_ctrl <= i_cpu_wdata;
                    3'd1: r_mask <= i_cpu_wdata;
                    3'd3: r_oam_addr <= i_cpu_wdata;
                    3'd4: r_oam_wdata <= i_cpu_wdata;
                    3'd5: if (r_w) r_sy <= i_cpu_wdata; else r_sx <= i_cpu_wdata;
                    3'd6: if (w_idle) begin
                        if (r_w) r_vaddr[7:0] <= i_cpu_wdata;
                        else r_vaddr[VADDR_W-1:8] <= i_cpu_wdata[VADDR_W-9:0];
                    end
                    default: ;
                endcase
            end
            if (w_wr && (i_reg_sel == 3'd5 || i_reg_sel == 3'd6)) r_w <= ~r_w;
            else if (w_rd2) r_w <= 1'b0;
            if (w_idle && w_acc7) begin
                r_state <= i_rw ? S_RD : S_WR;
                r_req   <= 1'b1;
                r_we    <= ~i_rw;
                r_pal   <= w_pal_rd;
                if (!i_rw) r_wdata <= i_cpu_wdata;
            end
            r_sh_hi_v <= w_hi_v; r_sh_lo_v <= w_lo_v; r_sh_hi <= w_hi; r_sh_lo <= w_lo;
            if (w_done) begin
                r_state   <= S_IDLE;
                r_req     <= 1'b0;
                r_pal     <= 1'b0;
                r_vaddr   <= w_vpost;
                r_sh_hi_v <= 1'b0;
                r_sh_lo_v <= 1'b0;
                if (r_state == S_RD) r_buf <= i_vram_rdata;
                if (r_pal) begin
                    r_rdata <= i_vram_rdata;
                    r_io    <= i_vram_rdata;
                end
            end
        end
    end
    assign o_cpu_rdata  = r_rdata;
    assign o_nmi_n      = r_nmi_n;
    assign o_ppu_ctrl   = r_ctrl;
    assign o_ppu_mask   = r_mask;
    assign o_scroll_x   = r_sx;
    assign o_scroll_y   = r_sy;
    assign o_oam_addr   = r_oam_addr;
    assign o_oam_wr     = r_oam_wr;
    assign o_oam_wdata  = r_oam_wdata;
    assign o_vram_addr  = r_vaddr;
    assign o_vram_req   = r_req;
    assign o_vram_we    = r_we;
    assign o_vram_wdata = r_wdata;
endmodule

// File: doc/ppu_reg_port.md
Name: ppu_reg_port

Overview:
- CPU-bus responder for the eight PPU registers at $2000-$2007, mirrored every 8 bytes.
- The cpu core drives addr/d_out and samples d_in. This block decodes the strobed access, holds the PPU control/status state, and bridges PPUDATA/OAMDATA accesses to VRAM (req/ack handshake) and to OAM.
- Sits between the CPU bus decoder and the PPU rendering core.

Parameters:
- VADDR_W, 14, VRAM address width; address wraps modulo 2^VADDR_W.
- PAL_BASE, 14'h3F00, first palette address (used by the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cs  in  1  one-cycle access strobe from the bus decoder ($2000-$3FFF)
- rw  in  1  1 = CPU read, 0 = CPU write; valid with cs
- reg_sel  in  3  CPU addr[2:0]
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  read data, registered
- nmi_n  out  1  active-low NMI to CPU
- vblank_set  in  1  one-cycle pulse from PPU timing at vblank start
- frame_clr  in  1  one-cycle pulse at pre-render line
- spr0_hit, spr_ovf  in  1  one-cycle set pulses from renderer
- ppu_ctrl, ppu_mask  out  8  register contents to renderer
- scroll_x, scroll_y  out  8  scroll values
- oam_addr  out  8  OAM pointer
- oam_wr  out  1  OAM write strobe
- oam_wdata  out  8  OAM write data
- oam_rdata  in  8  OAM read data, combinational from oam_addr
- vram_addr  out  VADDR_W  VRAM access pointer
- vram_req  out  1  VRAM request, held until ack
- vram_we  out  1  1 = write; stable while vram_req
- vram_wdata  out  8  VRAM write data
- vram_rdata  in  8  valid with vram_ack on reads
- vram_ack  in  1  one-cycle completion

Behaviour:
- Reset (rst=0, async): all outputs and internal registers = 0, including the write toggle w, the read buffer, the open-bus latch and the vblank/spr0/ovf flags. nmi_n=1. FSM=IDLE.
- An access takes effect on the clk edge where cs=1. cpu_rdata updates on that same edge (visible the next cycle, latency 1). cpu_rdata holds between reads.
- Open-bus latch io: loaded with cpu_wdata on every write and with the returned value on every read. Reads of write-only registers (0, 1, 3, 5, 6) return io.
- Reg 0 write: ppu_ctrl. Reg 1 write: ppu_mask. Reg 3 write: oam_addr.
- Reg 2 read returns {vblank, spr0, ovf, io[4:0]}, then clears vblank and w.
  - If vblank_set coincides with a reg 2 read: return bit7=0 and leave vblank clear (read wins).
  - frame_clr clears vblank, spr0 and ovf.
  - frame_clr and vblank_set never coincide; if they do, set wins.
- Reg 4 read returns oam_rdata with no increment.
- Reg 4 write: oam_wr pulses 1 cycle with oam_wdata=cpu_wdata, then oam_addr+1 (wraps 255->0).
- Reg 5 write: w=0 loads scroll_x, w=1 loads scroll_y; w toggles.
- Reg 6 write: w=0 loads vram_addr[13:8]=cpu_wdata[5:0]; w=1 loads vram_addr[7:0]; w toggles.
- Increment = 32 if ppu_ctrl[2], else 1. vram_addr wraps 3FFF->0000.
- FSM states: IDLE, RD_WAIT, WR_WAIT.
  - IDLE + reg 7 read: return read buffer; vram_req=1, vram_we=0 at current addr; -> RD_WAIT.
  - IDLE + reg 7 write: vram_req=1, vram_we=1, vram_wdata=cpu_wdata; -> WR_WAIT.
  - RD_WAIT + vram_ack: buffer <= vram_rdata; vram_addr += inc; -> IDLE.
  - WR_WAIT + vram_ack: vram_addr += inc; -> IDLE.
  - vram_req deasserts the cycle after ack. vram_addr and vram_wdata are stable while vram_req=1.
- Reg 7 access while not IDLE is dropped: no VRAM request, no increment. A read returns the current buffer; io still updates.
- Reg 6 write while not IDLE updates the pointer only after the pending transfer completes; it is held in a one-entry shadow.
- nmi_n = ~(vblank & ppu_ctrl[7]). Registered: updates one cycle after either term changes.
- Toggle w is shared by regs 5 and 6 and is cleared only by a reg 2 read or reset.

Optional Feature:
- Macro PPU_PALETTE_DIRECT_EN.
- Defined: a reg 7 read with vram_addr >= PAL_BASE waits for ack and returns vram_rdata directly.
  - cpu_rdata is updated on the ack edge, not the strobe edge.
  - The buffer is still loaded from the same ack.
- Undefined: palette reads are buffered like all other addresses.

Test Plan:
- Reset, then write $2006=$21, $2006=$08, $2007=$5A, ack after 3 cycles -> vram_req/we high at addr $2108, wdata $5A; vram_addr=$2109 after ack.
- ppu_ctrl[2]=1, read $2007 twice with vram_rdata $11 then $22 -> returns old buffer (0) then $11; vram_addr advances by 32 each time.
- vram_set with ppu_ctrl=$80 -> nmi_n=0 next cycle; read $2002 -> bit7=1, nmi_n=1 afterwards. vblank_set coincident with a $2002 read -> returns bit7=0.
- Write $2005=$10, read $2002, write $2005=$20 -> scroll_x=$20, scroll_y unchanged (toggle reset).
- $2003=$FF, $2004 write $AB -> oam_wr pulse with data $AB at addr $FF; oam_addr=$00 after.
- $2007 write while WR_WAIT -> no second vram_req, single increment; assert rst mid-RD_WAIT -> vram_req=0, FSM IDLE immediately.
